// File: rtl/instr_fetch_unit_if.sv
// Memory read bus between the instruction fetch unit and instruction memory.
// Handshake: the fetch unit holds mem_rd=1 with a stable mem_addr for as long
// as it wants a byte; the memory answers with mem_ready=1 and mem_data in the
// cycle the byte is valid. A byte transfers in any cycle where mem_rd and
// mem_ready are both 1. mem_ready while mem_rd=0 carries no meaning.
interface instr_fetch_unit_if;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_ready;

    modport master (output mem_rd, output mem_addr, input mem_data, input mem_ready);
    modport slave  (input mem_rd, input mem_addr, output mem_data, output mem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: on start, reads a 16-bit instruction as two bytes
// (low byte at PC, high byte at PC+1), steering the instruction register and
// PC register with one-cycle strobes per accepted byte. A byte that waits
// TIMEOUT cycles without mem_ready aborts the fetch with a one-cycle err.
module instr_fetch_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [7:0]                 PC_in,
    instr_fetch_unit_if.master         mem,
    output logic                       IR_enable,
    output logic [1:0]                 IR_select,
    output logic                       IR_LH,
    output logic                       PC_enable,
    output logic [1:0]                 PC_select,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [15:0]                instr,
    output logic [2:0]                 state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        REQ_HI = 3'd2,
        DONE   = 3'd3,
        ABORT  = 3'd4
    } state_t;

    // Wait count at which a still-missing byte gives up.
    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] instr_q, instr_d;

    // State, latched address, wait counter and instruction copy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= 8'h00;
            wait_q  <= 4'h0;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic plus all outputs; a mem_ready on the timeout cycle
    // still accepts the byte because it is tested before the timeout.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wait_d       = wait_q;
        instr_d      = instr_q;
        mem.mem_rd   = 1'b0;
        mem.mem_addr = 8'h00;
        IR_enable    = 1'b0;
        IR_select    = 2'b00;
        IR_LH        = 1'b0;
        PC_enable    = 1'b0;
        PC_select    = 2'b00;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = PC_in;
                    wait_d  = 4'h0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                mem.mem_rd   = 1'b1;
                mem.mem_addr = addr_q;
                busy         = 1'b1;
                if (mem.mem_ready) begin
                    IR_enable     = 1'b1;
                    IR_select     = 2'b01;
                    IR_LH         = 1'b0;
                    PC_enable     = 1'b1;
                    PC_select     = 2'b11;
                    instr_d[7:0]  = mem.mem_data;
                    wait_d        = 4'h0;
                    state_d       = REQ_HI;
                end else if (wait_q == LAST_WAIT) begin
                    wait_d  = 4'h0;
                    state_d = ABORT;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            REQ_HI: begin
                mem.mem_rd   = 1'b1;
                mem.mem_addr = addr_q + 8'd1;
                busy         = 1'b1;
                if (mem.mem_ready) begin
                    IR_enable     = 1'b1;
                    IR_select     = 2'b01;
                    IR_LH         = 1'b1;
                    PC_enable     = 1'b1;
                    PC_select     = 2'b11;
                    instr_d[15:8] = mem.mem_data;
                    wait_d        = 4'h0;
                    state_d       = DONE;
                end else if (wait_q == LAST_WAIT) begin
                    wait_d  = 4'h0;
                    state_d = ABORT;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ABORT: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr     = instr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, a reset-mid-fetch
// sequence, and randomized fetches against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 15;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  PC_in;
    logic        IR_enable;
    logic [1:0]  IR_select;
    logic        IR_LH;
    logic        PC_enable;
    logic [1:0]  PC_select;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] instr;
    logic [2:0]  state_dbg;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .PC_in     (PC_in),
        .mem       (bus),
        .IR_enable (IR_enable),
        .IR_select (IR_select),
        .IR_LH     (IR_LH),
        .PC_enable (PC_enable),
        .PC_select (PC_select),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .instr     (instr),
        .state_dbg (state_dbg)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  dlo;
        logic [7:0]  dhi;
        int          wlo;
        int          whi;
        int          kind;   // 1 = done, 2 = err
        int          lat;    // cycle of done/err, start cycle = 1
        int          pcp;    // PC_enable pulses
        logic [15:0] instr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation from the fetch rules.
    task automatic predict(input int wlo, input int whi, input logic [7:0] dlo,
                           input logic [7:0] dhi, input logic [15:0] prev,
                           output int kind, output int lat, output int pcp,
                           output logic [15:0] nxt);
        if (wlo >= TIMEOUT) begin
            kind = 2; lat = 2 + TIMEOUT; pcp = 0; nxt = prev;
        end else if (whi >= TIMEOUT) begin
            kind = 2; lat = 3 + wlo + TIMEOUT; pcp = 1; nxt = {prev[15:8], dlo};
        end else begin
            kind = 1; lat = 4 + wlo + whi; pcp = 2; nxt = {dhi, dlo};
        end
    endtask

    // Drives one fetch cycle by cycle, acting as memory with wlo/whi wait
    // cycles, and records the outcome. noisy adds stray start/mem_ready.
    task automatic run_fetch(input logic [7:0] pc, input logic [7:0] dlo,
                             input logic [7:0] dhi, input int wlo, input int whi,
                             input bit noisy, output int kind, output int lat,
                             output int pcp, output int irp);
        int cyc;
        int nacc;
        int waitc;
        int w;
        kind = 0; lat = 0; pcp = 0; irp = 0;
        start = 1'b1;
        PC_in = pc;
        bus.mem_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_data  = 8'($urandom);
        @(negedge clock);
        chk("idle_quiet", 32'({bus.mem_rd, busy, IR_enable, PC_enable, done, err}), 32'd0);
        @(posedge clock); #1;
        cyc = 2; nacc = 0; waitc = 0;
        while (kind == 0 && cyc < 60) begin
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) PC_in = 8'($urandom);
            if (bus.mem_rd) begin
                w = (nacc == 0) ? wlo : whi;
                bus.mem_ready = (waitc == w);
                bus.mem_data  = (waitc == w) ? ((nacc == 0) ? dlo : dhi) : 8'($urandom);
            end else begin
                bus.mem_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_data  = 8'($urandom);
            end
            @(negedge clock);
            pcp += int'(PC_enable);
            irp += int'(IR_enable);
            chk("busy_eq_rd", 32'(busy), 32'(bus.mem_rd));
            if (bus.mem_rd) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(8'(pc + 8'(nacc))));
                if (bus.mem_ready) begin
                    chk("strobes", 32'({IR_enable, IR_select, IR_LH, PC_enable, PC_select}),
                        32'({1'b1, 2'b01, 1'(nacc), 1'b1, 2'b11}));
                    nacc++;
                    waitc = 0;
                end else begin
                    chk("no_strobe_wait", 32'({IR_enable, IR_select, IR_LH, PC_enable, PC_select}), 32'd0);
                    waitc++;
                end
            end else begin
                chk("no_strobe_end", 32'({IR_enable, IR_select, IR_LH, PC_enable, PC_select}), 32'd0);
                chk("not_both", 32'(done & err), 32'd0);
                if (done) kind = 1;
                else if (err) kind = 2;
                lat = cyc;
            end
            @(posedge clock); #1;
            cyc++;
        end
        if (kind == 0) chk("fetch_end_bound", 32'(cyc), 32'd0);
        start = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clock);
        chk("pulse_one_cycle", 32'({done, err, busy}), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        int kind, lat, pcp, irp;
        int ekind, elat, epcp;
        logic [15:0] exp_instr, nxt;
        logic [7:0] pc, dlo, dhi;
        int wlo, whi;

        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start = 1'b0;
        PC_in = 8'h00;
        bus.mem_ready = 1'b0;
        bus.mem_data = 8'h00;

        vecs[0] = '{8'h10, 8'h34, 8'h12, 0,  0,  1, 4,  2, 16'h1234};
        vecs[1] = '{8'h20, 8'hAB, 8'hCD, 3,  3,  1, 10, 2, 16'hCDAB};
        vecs[2] = '{8'hFF, 8'h11, 8'h22, 0,  0,  1, 4,  2, 16'h2211};
        vecs[3] = '{8'h40, 8'h56, 8'h78, 0,  15, 2, 18, 1, 16'h2256};
        vecs[4] = '{8'h50, 8'h9A, 8'hBC, 0,  14, 1, 18, 2, 16'hBC9A};
        vecs[5] = '{8'h60, 8'h01, 8'h02, 14, 0,  1, 18, 2, 16'h0201};
        vecs[6] = '{8'h70, 8'h33, 8'h44, 15, 0,  2, 17, 0, 16'h0201};
        vecs[7] = '{8'h80, 8'hEE, 8'hFF, 1,  2,  1, 7,  2, 16'hFFEE};

        // Reset state
        #2;
        chk("rst_outputs", 32'({bus.mem_rd, busy, done, err, IR_enable, PC_enable,
                                IR_select, PC_select, IR_LH, bus.mem_addr}), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_idle", 32'({busy, bus.mem_rd}), 32'd0);
        @(posedge clock); #1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_fetch(vecs[i].pc, vecs[i].dlo, vecs[i].dhi, vecs[i].wlo, vecs[i].whi,
                      (i % 2) == 1, kind, lat, pcp, irp);
            chk("vec_kind", 32'(kind), 32'(vecs[i].kind));
            chk("vec_latency", 32'(lat), 32'(vecs[i].lat));
            chk("vec_pc_pulses", 32'(pcp), 32'(vecs[i].pcp));
            chk("vec_ir_pulses", 32'(irp), 32'(vecs[i].pcp));
            chk("vec_instr", 32'(instr), 32'(vecs[i].instr));
        end
        exp_instr = vecs[7].instr;

        // Reset while waiting on the high byte
        start = 1'b1; PC_in = 8'h90; bus.mem_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0; bus.mem_ready = 1'b1; bus.mem_data = 8'h5A;
        @(posedge clock); #1;
        bus.mem_ready = 1'b1; bus.mem_data = 8'hA5;
        #1;
        chk("pre_rst_strobe", 32'({IR_enable, IR_LH, busy}), 32'b111);
        chk("pre_rst_lo", 32'(instr), 32'({exp_instr[15:8], 8'h5A}));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 32'({bus.mem_rd, busy, done, err, IR_enable, PC_enable,
                                    IR_select, PC_select, IR_LH, bus.mem_addr}), 32'd0);
        chk("mid_rst_instr", 32'(instr), 32'd0);
        @(posedge clock); #1;
        chk("rst_hold_quiet", 32'({IR_enable, PC_enable, done, err}), 32'd0);
        reset_n = 1'b1; bus.mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("after_rst_no_done", 32'({done, err, busy}), 32'd0);
        end
        @(posedge clock); #1;
        exp_instr = 16'h0000;

        // Randomized fetches against the model
        for (int n = 0; n < 24; n++) begin
            pc  = 8'($urandom);
            dlo = 8'($urandom);
            dhi = 8'($urandom);
            wlo = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 4));
            whi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 4));
            predict(wlo, whi, dlo, dhi, exp_instr, ekind, elat, epcp, nxt);
            run_fetch(pc, dlo, dhi, wlo, whi, 1'b1, kind, lat, pcp, irp);
            chk("rnd_kind", 32'(kind), 32'(ekind));
            chk("rnd_latency", 32'(lat), 32'(elat));
            chk("rnd_pc_pulses", 32'(pcp), 32'(epcp));
            chk("rnd_instr", 32'(instr), 32'(nxt));
            exp_instr = nxt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
